// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: memory-wait freeze with timeout,
// EX redirect flush and load-use bubbles, plus saturating stall/flush counters.
module hazard_ctrl #(
  parameter int LU_BUBBLES  = 1,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_id_vld,
  input  logic [4:0]       i_id_rs1_addr,
  input  logic [4:0]       i_id_rs2_addr,
  input  logic             i_id_rs1_used,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_ex_rd_addr,
  input  logic             i_ex_mem_rden,
  input  logic             i_ex_redirect,
  input  logic             i_mem_req,
  input  logic             i_mem_ack,
  output logic             o_pc_en,
  output logic             o_if_id_stall,
  output logic             o_if_id_flush,
  output logic             o_id_ex_stall,
  output logic             o_id_ex_flush,
  output logic             o_ex_mem_stall,
  output logic             o_mem_wb_flush,
  output logic             o_mem_err,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LU   = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] LU_INIT = 4'(LU_BUBBLES - 1);
  localparam logic [7:0] TMO     = 8'(MEM_TIMEOUT);

  state_t           state, state_nxt, ret, ret_nxt, eff;
  logic [3:0]       rem, rem_nxt;
  logic [7:0]       wcnt, wcnt_nxt;
  logic             lu, timeout, ms, act_redirect, act_bubble;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // Hazard decode; on a release cycle out of MEM_WAIT the saved return state governs behaviour.
  always_comb begin
    lu = i_id_vld & i_ex_mem_rden & (i_ex_rd_addr != 5'd0) &
         ((i_id_rs1_used & (i_id_rs1_addr == i_ex_rd_addr)) |
          (i_id_rs2_used & (i_id_rs2_addr == i_ex_rd_addr)));
    timeout      = (state == ST_WAIT) & (wcnt == TMO) & ~i_mem_ack;
    ms           = i_mem_req & ~i_mem_ack & ~timeout;
    eff          = (state == ST_WAIT) ? ret : state;
    act_redirect = ~ms & i_ex_redirect & (eff != ST_LU);
    act_bubble   = ~ms & ~act_redirect & ((eff == ST_LU) | lu);
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    ret_nxt   = ret;
    rem_nxt   = rem;
    wcnt_nxt  = wcnt;
    if (ms) begin
      if (state == ST_WAIT) begin
        wcnt_nxt = wcnt + 8'd1;
      end else begin
        state_nxt = ST_WAIT;
        ret_nxt   = state;
        wcnt_nxt  = 8'd2;
      end
    end else if (eff == ST_LU) begin
      if (rem == 4'd1) begin
        state_nxt = ST_RUN;
        rem_nxt   = 4'd0;
      end else begin
        state_nxt = ST_LU;
        rem_nxt   = rem - 4'd1;
      end
    end else if (act_bubble && (LU_BUBBLES > 1)) begin
      state_nxt = ST_LU;
      rem_nxt   = LU_INIT;
    end else begin
      state_nxt = ST_RUN;
    end
  end

  // Output decode, reset forces a flush of the front end
  always_comb begin
    o_pc_en        = 1'b0;
    o_if_id_stall  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_stall  = 1'b0;
    o_id_ex_flush  = 1'b0;
    o_ex_mem_stall = 1'b0;
    o_mem_wb_flush = 1'b0;
    if (!i_reset) begin
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (ms) begin
      o_if_id_stall  = 1'b1;
      o_id_ex_stall  = 1'b1;
      o_ex_mem_stall = 1'b1;
      o_mem_wb_flush = 1'b1;
    end else if (act_redirect) begin
      o_pc_en       = 1'b1;
      o_if_id_flush = 1'b1;
      o_id_ex_flush = 1'b1;
    end else if (act_bubble) begin
      o_if_id_stall = 1'b1;
      o_id_ex_flush = 1'b1;
    end else begin
      o_pc_en = 1'b1;
    end
  end

  // State, sticky error and saturating counters
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state     <= ST_RUN;
      ret       <= ST_RUN;
      rem       <= 4'd0;
      wcnt      <= 8'd0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      ret   <= ret_nxt;
      rem   <= rem_nxt;
      wcnt  <= wcnt_nxt;
      if (timeout) mem_err <= 1'b1;
      if (!o_pc_en && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + CNT_W'(1);
      if (act_redirect && (flush_cnt != {CNT_W{1'b1}})) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign o_mem_err   = mem_err;
  assign o_stall_cnt = stall_cnt;
  assign o_flush_cnt = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LU_BUBBLES=3/MEM_TIMEOUT=4 and LU_BUBBLES=1/MEM_TIMEOUT=64
// with 8-bit counters) share stimulus; directed scenarios plus random traffic against a model.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, id_vld, rs1_used, rs2_used, ex_rden, redirect, mem_req, mem_ack;
  logic [4:0] rs1, rs2, ex_rd;
  wire  [6:0] ov0, ov1;
  wire        err0, err1;
  wire [31:0] sc0, fc0;
  wire  [7:0] sc1, fc1;

  localparam logic [6:0] V_RST = 7'b0010100;
  localparam logic [6:0] V_FRZ = 7'b0101011;
  localparam logic [6:0] V_RED = 7'b1010100;
  localparam logic [6:0] V_BUB = 7'b0100100;
  localparam logic [6:0] V_NRM = 7'b1000000;

  int checks = 0;
  int passed = 0;

  hazard_ctrl #(.LU_BUBBLES(3), .MEM_TIMEOUT(4), .CNT_W(32)) dut0 (
    .i_clk(clk), .i_reset(reset), .i_id_vld(id_vld), .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
    .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used), .i_ex_rd_addr(ex_rd),
    .i_ex_mem_rden(ex_rden), .i_ex_redirect(redirect), .i_mem_req(mem_req), .i_mem_ack(mem_ack),
    .o_pc_en(ov0[6]), .o_if_id_stall(ov0[5]), .o_if_id_flush(ov0[4]), .o_id_ex_stall(ov0[3]),
    .o_id_ex_flush(ov0[2]), .o_ex_mem_stall(ov0[1]), .o_mem_wb_flush(ov0[0]),
    .o_mem_err(err0), .o_stall_cnt(sc0), .o_flush_cnt(fc0));

  hazard_ctrl #(.LU_BUBBLES(1), .MEM_TIMEOUT(64), .CNT_W(8)) dut1 (
    .i_clk(clk), .i_reset(reset), .i_id_vld(id_vld), .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
    .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used), .i_ex_rd_addr(ex_rd),
    .i_ex_mem_rden(ex_rden), .i_ex_redirect(redirect), .i_mem_req(mem_req), .i_mem_ack(mem_ack),
    .o_pc_en(ov1[6]), .o_if_id_stall(ov1[5]), .o_if_id_flush(ov1[4]), .o_id_ex_stall(ov1[3]),
    .o_id_ex_flush(ov1[2]), .o_ex_mem_stall(ov1[1]), .o_mem_wb_flush(ov1[0]),
    .o_mem_err(err1), .o_stall_cnt(sc1), .o_flush_cnt(fc1));

  // Reference model: bubbles still owed, frozen cycles of the current access, sticky error, counts.
  int          lbv [2] = '{3, 1};
  int          mtv [2] = '{4, 64};
  logic [31:0] cap [2] = '{32'hFFFF_FFFF, 32'd255};
  int          m_owed [2];
  int          m_frozen [2];
  bit          m_err [2];
  logic [31:0] m_sc [2];
  logic [31:0] m_fc [2];

  function automatic bit m_lu();
    return id_vld && ex_rden && (ex_rd != 5'd0) &&
           ((rs1_used && rs1 == ex_rd) || (rs2_used && rs2 == ex_rd));
  endfunction

  function automatic bit m_timeout(int k);
    return (m_frozen[k] > 0) && (m_frozen[k] == mtv[k] - 1) && !mem_ack;
  endfunction

  function automatic bit m_freeze(int k);
    return mem_req && !mem_ack && !m_timeout(k);
  endfunction

  function automatic logic [6:0] m_out(int k);
    if (!reset) return V_RST;
    if (m_freeze(k)) return V_FRZ;
    if (redirect && m_owed[k] == 0) return V_RED;
    if (m_owed[k] > 0 || m_lu()) return V_BUB;
    return V_NRM;
  endfunction

  // Advance the model with the current inputs, then step the clock.
  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      bit to, fr;
      to = m_timeout(k);
      fr = m_freeze(k);
      if (!reset) begin
        m_owed[k] = 0; m_frozen[k] = 0; m_err[k] = 1'b0; m_sc[k] = 32'd0; m_fc[k] = 32'd0;
      end else if (fr) begin
        m_frozen[k]++;
        if (m_sc[k] != cap[k]) m_sc[k]++;
      end else begin
        if (to) m_err[k] = 1'b1;
        m_frozen[k] = 0;
        if (redirect && m_owed[k] == 0) begin
          if (m_fc[k] != cap[k]) m_fc[k]++;
        end else if (m_owed[k] > 0) begin
          m_owed[k]--;
          if (m_sc[k] != cap[k]) m_sc[k]++;
        end else if (m_lu()) begin
          m_owed[k] = lbv[k] - 1;
          if (m_sc[k] != cap[k]) m_sc[k]++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_vld = 1'b0; rs1 = 5'd0; rs2 = 5'd0; rs1_used = 1'b0; rs2_used = 1'b0;
    ex_rd = 5'd0; ex_rden = 1'b0; redirect = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic load_use(input logic [4:0] rd);
    id_vld = 1'b1; rs1 = 5'd7; rs1_used = 1'b1; rs2 = rd; rs2_used = 1'b1;
    ex_rd = rd; ex_rden = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++; if (ov0 !== V_RST) $display("FAIL reset_out0 c%0d got=%b exp=%b", i, ov0, V_RST); else passed++;
      checks++; if (ov1 !== V_RST) $display("FAIL reset_out1 c%0d got=%b exp=%b", i, ov1, V_RST); else passed++;
      tick();
    end
    reset = 1'b1;
    #2;
    checks++; if (ov0 !== V_NRM) $display("FAIL reset_release got=%b exp=%b", ov0, V_NRM); else passed++;
    checks++; if (sc0 !== 32'd0 || fc0 !== 32'd0 || err0 !== 1'b0)
      $display("FAIL reset_state sc=%0d fc=%0d err=%b exp=0/0/0", sc0, fc0, err0); else passed++;
    tick();
  endtask

  task automatic test_load_use();
    logic [6:0] e0, e1;
    idle(); do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) load_use(5'd5); else idle();
      #2;
      e0 = (i < 3) ? V_BUB : V_NRM;
      e1 = (i < 1) ? V_BUB : V_NRM;
      checks++; if (ov0 !== e0) $display("FAIL lu3 c%0d got=%b exp=%b", i, ov0, e0); else passed++;
      checks++; if (ov1 !== e1) $display("FAIL lu1 c%0d got=%b exp=%b", i, ov1, e1); else passed++;
      tick();
    end
    #2;
    checks++; if (sc0 !== 32'd3) $display("FAIL lu3_stall_cnt got=%0d exp=3", sc0); else passed++;
    checks++; if (sc1 !== 8'd1) $display("FAIL lu1_stall_cnt got=%0d exp=1", sc1); else passed++;
    do_reset();
    load_use(5'd0);
    #2;
    checks++; if (ov0 !== V_NRM) $display("FAIL lu_x0 got=%b exp=%b", ov0, V_NRM); else passed++;
    tick();
    idle();
    #2;
    checks++; if (sc0 !== 32'd0 || sc1 !== 8'd0) $display("FAIL lu_x0_cnt got=%0d/%0d exp=0/0", sc0, sc1); else passed++;
  endtask

  task automatic test_mem_wait();
    logic [6:0] e;
    logic [6:0] seq [6];
    idle(); do_reset();
    for (int i = 0; i < 7; i++) begin
      mem_req = (i < 6); mem_ack = (i == 5);
      #2;
      e = (i < 5) ? V_FRZ : V_NRM;
      checks++; if (ov1 !== e) $display("FAIL memwait c%0d got=%b exp=%b", i, ov1, e); else passed++;
      tick();
    end
    #2;
    checks++; if (sc1 !== 8'd5) $display("FAIL memwait_cnt got=%0d exp=5", sc1); else passed++;
    // ack lands while LU_BUBBLES=3 hazard is part-way done
    seq = '{V_BUB, V_FRZ, V_FRZ, V_BUB, V_BUB, V_NRM};
    idle(); do_reset();
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i == 0) load_use(5'd9);
      mem_req = (i >= 1 && i <= 3); mem_ack = (i == 3);
      #2;
      checks++; if (ov0 !== seq[i]) $display("FAIL memwait_lu c%0d got=%b exp=%b", i, ov0, seq[i]); else passed++;
      tick();
    end
    idle();
    #2;
    checks++; if (sc0 !== 32'd5) $display("FAIL memwait_lu_cnt got=%0d exp=5", sc0); else passed++;
  endtask

  task automatic test_timeout();
    logic [6:0] e;
    idle(); do_reset();
    for (int i = 0; i < 8; i++) begin
      mem_req = (i < 4);
      #2;
      e = (i < 3) ? V_FRZ : V_NRM;
      checks++; if (ov0 !== e) $display("FAIL timeout c%0d got=%b exp=%b", i, ov0, e); else passed++;
      checks++; if (err0 !== (i >= 4)) $display("FAIL mem_err c%0d got=%b exp=%b", i, err0, (i >= 4)); else passed++;
      tick();
    end
    do_reset();
    #2;
    checks++; if (err0 !== 1'b0) $display("FAIL mem_err_clear got=%b exp=0", err0); else passed++;
  endtask

  task automatic test_redirect();
    logic [6:0] seq [4];
    seq = '{V_RED, V_RED, V_FRZ, V_NRM};
    idle(); do_reset();
    for (int i = 0; i < 4; i++) begin
      redirect = (i < 3); mem_req = (i == 2);
      #2;
      checks++; if (ov0 !== seq[i]) $display("FAIL redirect c%0d got=%b exp=%b", i, ov0, seq[i]); else passed++;
      tick();
    end
    checks++; if (fc0 !== 32'd2) $display("FAIL flush_cnt got=%0d exp=2", fc0); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [6:0] s0 [4];
    logic [6:0] s1 [4];
    s0 = '{V_BUB, V_BUB, V_BUB, V_NRM};
    s1 = '{V_BUB, V_RED, V_NRM, V_NRM};
    idle(); do_reset();
    for (int i = 0; i < 4; i++) begin
      idle();
      if (i == 0) load_use(5'd3);
      redirect = (i == 1);
      #2;
      checks++; if (ov0 !== s0[i]) $display("FAIL b2b_lu3 c%0d got=%b exp=%b", i, ov0, s0[i]); else passed++;
      checks++; if (ov1 !== s1[i]) $display("FAIL b2b_lu1 c%0d got=%b exp=%b", i, ov1, s1[i]); else passed++;
      tick();
    end
    checks++; if (fc0 !== 32'd0 || fc1 !== 8'd1) $display("FAIL b2b_flush got=%0d/%0d exp=0/1", fc0, fc1); else passed++;
  endtask

  task automatic test_random();
    logic [6:0]  ov;
    logic [31:0] sc, fc;
    logic        er;
    idle(); do_reset();
    for (int n = 0; n < 1500; n++) begin
      reset    = ($urandom_range(0, 299) != 0);
      id_vld   = ($urandom_range(0, 3) != 0);
      rs1      = 5'($urandom_range(0, 3));
      rs2      = 5'($urandom_range(0, 3));
      ex_rd    = 5'($urandom_range(0, 3));
      rs1_used = 1'($urandom_range(0, 1));
      rs2_used = 1'($urandom_range(0, 1));
      ex_rden  = 1'($urandom_range(0, 1));
      redirect = ($urandom_range(0, 5) == 0);
      mem_req  = ($urandom_range(0, 2) == 0);
      mem_ack  = ($urandom_range(0, 2) == 0);
      #2;
      for (int k = 0; k < 2; k++) begin
        ov = (k == 0) ? ov0 : ov1;
        sc = (k == 0) ? sc0 : {24'd0, sc1};
        fc = (k == 0) ? fc0 : {24'd0, fc1};
        er = (k == 0) ? err0 : err1;
        checks++; if (ov !== m_out(k)) $display("FAIL rnd_out%0d n%0d got=%b exp=%b", k, n, ov, m_out(k)); else passed++;
        checks++; if (sc !== m_sc[k]) $display("FAIL rnd_stall%0d n%0d got=%0d exp=%0d", k, n, sc, m_sc[k]); else passed++;
        checks++; if (fc !== m_fc[k]) $display("FAIL rnd_flush%0d n%0d got=%0d exp=%0d", k, n, fc, m_fc[k]); else passed++;
        checks++; if (er !== m_err[k]) $display("FAIL rnd_err%0d n%0d got=%b exp=%b", k, n, er, m_err[k]); else passed++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_redirect();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
